// File: rtl/cfg_bank_pkg.sv
// Shared definitions for the configuration-bank loader family.
//   state_t    : loader FSM states
//   ceil_div   : integer ceiling division
//   clog2      : ceiling log2 (clog2(1) = 0)
//   cnt_w      : counter width able to index n values, never below 1 bit
//   beat_cnt_w : beat-counter width for a BL_WIDTH row fed DATA_W bits per beat
package cfg_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int beat_cnt_w(input int bl_width, input int data_w);
    return cnt_w(ceil_div(bl_width, data_w));
  endfunction

endpackage

// File: rtl/cfg_wl_decoder.sv
// Registered one-hot word-line decoder.
//   clk    : clock
//   reset  : synchronous, active-low; clears all word-lines
//   row    : row index to select
//   en     : drive the selected word-line on the next cycle
//   wl_out : one-hot (or all-zero) word-line vector, registered
module cfg_wl_decoder #(
  parameter int WL_WIDTH = 4,
  parameter int ROW_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ROW_W-1:0]    row,
  input  logic                en,
  output logic [WL_WIDTH-1:0] wl_out
);

  logic [WL_WIDTH-1:0] wl_d, wl_q;

  always_comb begin
    wl_d = '0;
    for (int i = 0; i < WL_WIDTH; i++) begin
      wl_d[i] = en && (row == ROW_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) wl_q <= '0;
    else        wl_q <= wl_d;
  end

  assign wl_out = wl_q;

endmodule

// File: rtl/cfg_bank_loader.sv
// Configuration-bank loader: assembles BL_WIDTH-bit rows from a DATA_W-bit
// valid/ready stream, then pulses one word-line per row, row 0 first.
//   clk       : clock
//   reset     : synchronous, active-low
//   start     : begin a full bank load (honoured in IDLE and DONE only)
//   cfg_data  : configuration word
//   cfg_valid : cfg_data valid
//   cfg_ready : word accepted this cycle when cfg_valid is also high (LOAD only)
//   bl_out    : assembled bit-line row, to tile bl_in
//   wl_out    : one-hot word-line pulse, to tile wl_in
//   busy      : high in LOAD / WRITE / HOLD
//   done      : high in DONE
module cfg_bank_loader
  import cfg_bank_pkg::*;
#(
  parameter int BL_WIDTH = 315,
  parameter int WL_WIDTH = 4,
  parameter int DATA_W   = 32,
  parameter int WL_PULSE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [BL_WIDTH-1:0] bl_out,
  output logic [WL_WIDTH-1:0] wl_out,
  output logic                busy,
  output logic                done
);

  localparam int BEATS   = ceil_div(BL_WIDTH, DATA_W);
  localparam int BEAT_W  = beat_cnt_w(BL_WIDTH, DATA_W);
  localparam int ROW_W   = cnt_w(WL_WIDTH);
  localparam int PULSE_W = cnt_w(WL_PULSE);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(WL_WIDTH - 1);
  localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(WL_PULSE - 1);

  state_t               state_d, state_q;
  logic [BEAT_W-1:0]    beat_d, beat_q;
  logic [ROW_W-1:0]     row_d, row_q;
  logic [PULSE_W-1:0]   pulse_d, pulse_q;
  logic [BL_WIDTH-1:0]  bl_d, bl_q;
  logic                 cfg_ready_d, cfg_ready_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 accept;
  logic                 wl_en;

  assign accept = cfg_valid && cfg_ready_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    pulse_d = pulse_q;
    bl_d    = bl_q;

    // Beat k lands in bits [k*DATA_W +: DATA_W]; bits beyond BL_WIDTH in the
    // last beat simply have no destination.
    for (int i = 0; i < BL_WIDTH; i++) begin
      if (accept && ((i / DATA_W) == int'(beat_q))) bl_d[i] = cfg_data[i % DATA_W];
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          beat_d  = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WRITE;
            pulse_d = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (pulse_q == LAST_PULSE) state_d = ST_HOLD;
        else                       pulse_d = pulse_q + 1'b1;
      end
      ST_HOLD: begin
        if (row_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          row_d   = row_q + 1'b1;
          beat_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    cfg_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_HOLD);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      row_q       <= '0;
      pulse_q     <= '0;
      bl_q        <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      pulse_q     <= pulse_d;
      bl_q        <= bl_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The decoder registers its output, so it is enabled from the next state:
  // the word-line rises in the same cycle the FSM enters WRITE.
  assign wl_en = (state_d == ST_WRITE);

  cfg_wl_decoder #(
    .WL_WIDTH (WL_WIDTH),
    .ROW_W    (ROW_W)
  ) u_wl_dec (
    .clk    (clk),
    .reset  (reset),
    .row    (row_q),
    .en     (wl_en),
    .wl_out (wl_out)
  );

  assign cfg_ready = cfg_ready_q;
  assign bl_out    = bl_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
